// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the pipeline sequencing controller and the datapath / branch control.
// The datapath side is the master (drives fetch byte, branch and hold inputs).
interface pipe_hazard_ctrl_if;
  logic [7:0] if_ins;
  logic       br_taken;
  logic       hold;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       id_imm;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    output if_ins, br_taken, hold,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, id_imm, fwd_a, fwd_b
  );

  modport slave (
    input  if_ins, br_taken, hold,
    output pc_en, ifid_en, ifid_flush, idex_bubble, id_imm, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID/EX/MEM/WB sequencing for the 8-bit core: stall, flush, hold and operand forwarding.
// Past ID only the producer/load attributes of each slot are needed, so that is all that is kept.
module pipe_hazard_ctrl (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] OP_LOAD    = 4'd13;
  localparam logic [3:0] OP_LOADIMM = 4'd15;

  function automatic logic op_reads_a(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14};
  endfunction

  function automatic logic op_reads_b(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14};
  endfunction

  function automatic logic op_produces(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd13};
  endfunction

  logic [7:0] id_q, id_d;
  logic       id_imm_q, id_imm_d;
  logic [1:0] imm_dest_q, imm_dest_d;   // ra of the LOADIMM that tagged the id byte
  logic       ex_prod_q, ex_prod_d;
  logic       ex_load_q, ex_load_d;
  logic [1:0] ex_dest_q, ex_dest_d;
  logic       mem_prod_q, mem_prod_d;
  logic [1:0] mem_dest_q, mem_dest_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic [3:0] id_op;
  logic [1:0] id_ra, id_rb;
  logic       id_rd_a, id_rd_b, id_prod;
  logic [1:0] id_dest;
  logic       load_use;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;

  function automatic logic [1:0] fwd_sel(input logic rd, input logic [1:0] src,
                                         input logic ex_p, input logic [1:0] ex_d,
                                         input logic mem_p, input logic [1:0] mem_d);
    if (!rd)                     return 2'b00;
    else if (ex_p && ex_d == src)   return 2'b01;
    else if (mem_p && mem_d == src) return 2'b10;
    else                         return 2'b00;
  endfunction

  always_comb begin
    id_op    = id_q[7:4];
    id_ra    = id_q[3:2];
    id_rb    = id_q[1:0];
    id_rd_a  = !id_imm_q && op_reads_a(id_op);
    id_rd_b  = !id_imm_q && op_reads_b(id_op);
    id_prod  = id_imm_q || op_produces(id_op);
    id_dest  = id_imm_q ? imm_dest_q : id_ra;
    load_use = ex_load_q && ((id_rd_a && id_ra == ex_dest_q) ||
                             (id_rd_b && id_rb == ex_dest_q));
  end

  // Priority: reset, then hold, then branch flush, then load-use stall.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_en = 1'b1;
    end else if (bus.hold) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (bus.br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    id_d       = id_q;
    id_imm_d   = id_imm_q;
    imm_dest_d = imm_dest_q;
    ex_prod_d  = ex_prod_q;
    ex_load_d  = ex_load_q;
    ex_dest_d  = ex_dest_q;
    mem_prod_d = mem_prod_q;
    mem_dest_d = mem_dest_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
    if (!bus.hold) begin
      if (ifid_flush) begin
        id_d       = 8'h00;
        id_imm_d   = 1'b0;
        imm_dest_d = 2'b00;
      end else if (ifid_en) begin
        id_d       = bus.if_ins;
        id_imm_d   = (id_op == OP_LOADIMM) && !id_imm_q;
        imm_dest_d = id_ra;
      end
      if (idex_bubble) begin
        ex_prod_d = 1'b0;
        ex_load_d = 1'b0;
        ex_dest_d = 2'b00;
        fwd_a_d   = 2'b00;
        fwd_b_d   = 2'b00;
      end else begin
        ex_prod_d = id_prod;
        ex_load_d = !id_imm_q && (id_op == OP_LOAD);
        ex_dest_d = id_dest;
        fwd_a_d   = fwd_sel(id_rd_a, id_ra, ex_prod_q, ex_dest_q, mem_prod_q, mem_dest_q);
        fwd_b_d   = fwd_sel(id_rd_b, id_rb, ex_prod_q, ex_dest_q, mem_prod_q, mem_dest_q);
      end
      mem_prod_d = ex_prod_q;
      mem_dest_d = ex_dest_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q       <= 8'h00;
      id_imm_q   <= 1'b0;
      imm_dest_q <= 2'b00;
      ex_prod_q  <= 1'b0;
      ex_load_q  <= 1'b0;
      ex_dest_q  <= 2'b00;
      mem_prod_q <= 1'b0;
      mem_dest_q <= 2'b00;
      fwd_a_q    <= 2'b00;
      fwd_b_q    <= 2'b00;
    end else begin
      id_q       <= id_d;
      id_imm_q   <= id_imm_d;
      imm_dest_q <= imm_dest_d;
      ex_prod_q  <= ex_prod_d;
      ex_load_q  <= ex_load_d;
      ex_dest_q  <= ex_dest_d;
      mem_prod_q <= mem_prod_d;
      mem_dest_q <= mem_dest_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.id_imm      = id_imm_q;
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed test-plan scenarios followed by a random program run, all checked against
// an instruction-level model of the pipeline driven by a small program memory and PC.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       imm;
    logic       prod;
    logic [1:0] dest;
    logic       ra_rd;
    logic       rb_rd;
    logic       is_load;
  } slot_t;

  // Bit n set means opcode n has the property.
  logic [15:0] rd_a_tab = 16'b0100_0000_0111_1110;
  logic [15:0] rd_b_tab = 16'b0110_1111_0000_1110;
  logic [15:0] prod_tab = 16'b0010_0001_1011_1110;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [64];
  int         pc;
  logic       br_v, hold_v, br_prev, hold_prev;
  int         tgt_v;
  slot_t      m_id, m_ex, m_mem;
  logic [1:0] m_fa, m_fb;
  logic       e_pc, e_ifid, e_fl, e_bub, e_stall;
  logic [7:0] if_cap;

  function automatic slot_t mk(logic [7:0] b, logic imm, logic [1:0] idest);
    slot_t s;
    s.b       = b;
    s.imm     = imm;
    s.ra_rd   = !imm && rd_a_tab[b[7:4]];
    s.rb_rd   = !imm && rd_b_tab[b[7:4]];
    s.prod    = imm || prod_tab[b[7:4]];
    s.dest    = imm ? idest : b[3:2];
    s.is_load = !imm && (b[7:4] == 4'd13);
    return s;
  endfunction

  function automatic logic [1:0] fsel(logic rd, logic [1:0] r);
    if (!rd) return 2'b00;
    if (m_ex.prod && m_ex.dest == r) return 2'b01;
    if (m_mem.prod && m_mem.dest == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_id  = mk(8'h00, 1'b0, 2'b00);
    m_ex  = m_id;
    m_mem = m_id;
    m_fa  = 2'b00;
    m_fb  = 2'b00;
    pc    = 0;
    br_prev = 1'b0;
    hold_prev = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 8'h00;
  endtask

  // Apply inputs for this cycle and compare every output with the model.
  task automatic prep();
    bus.if_ins   = prog[pc];
    bus.br_taken = br_v;
    bus.hold     = hold_v;
    if_cap       = prog[pc];
    #1;
    e_stall = m_ex.is_load && ((m_id.ra_rd && m_id.b[3:2] == m_ex.dest) ||
                               (m_id.rb_rd && m_id.b[1:0] == m_ex.dest));
    if (hold_v)         begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; end
    else if (br_v)      begin e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1; end
    else if (e_stall)   begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; end
    else                begin e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; end
    chk("pc_en",       8'(bus.pc_en),       8'(e_pc));
    chk("ifid_en",     8'(bus.ifid_en),     8'(e_ifid));
    chk("ifid_flush",  8'(bus.ifid_flush),  8'(e_fl));
    chk("idex_bubble", 8'(bus.idex_bubble), 8'(e_bub));
    chk("id_imm",      8'(bus.id_imm),      8'(m_id.imm));
    chk("fwd_a",       8'(bus.fwd_a),       8'(m_fa));
    chk("fwd_b",       8'(bus.fwd_b),       8'(m_fb));
  endtask

  task automatic clk_adv();
    slot_t nop, nid;
    @(posedge clk);
    nop = mk(8'h00, 1'b0, 2'b00);
    if (!hold_v) begin
      if (e_fl)         nid = nop;
      else if (e_stall) nid = m_id;
      else nid = mk(if_cap, !m_id.imm && (m_id.b[7:4] == 4'd15), m_id.b[3:2]);
      m_fa  = e_bub ? 2'b00 : fsel(m_id.ra_rd, m_id.b[3:2]);
      m_fb  = e_bub ? 2'b00 : fsel(m_id.rb_rd, m_id.b[1:0]);
      m_mem = m_ex;
      m_ex  = e_bub ? nop : m_id;
      m_id  = nid;
      if (e_fl)      pc = tgt_v;
      else if (e_pc) pc = (pc + 1) % 64;
    end
    br_prev   = br_v;
    hold_prev = hold_v;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) begin
      prep();
      clk_adv();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br_v = 1'b0; hold_v = 1'b0; tgt_v = 0;
    bus.if_ins = 8'h00; bus.br_taken = 1'b0; bus.hold = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_pc_en"},   8'(bus.pc_en),       8'h01);
    chk({tag, "_ifid_en"}, 8'(bus.ifid_en),     8'h01);
    chk({tag, "_flush"},   8'(bus.ifid_flush),  8'h00);
    chk({tag, "_bubble"},  8'(bus.idex_bubble), 8'h00);
    chk({tag, "_id_imm"},  8'(bus.id_imm),      8'h00);
    chk({tag, "_fwd_a"},   8'(bus.fwd_a),       8'h00);
    chk({tag, "_fwd_b"},   8'(bus.fwd_b),       8'h00);
  endtask

  initial begin
    bus.if_ins = 8'h00; bus.br_taken = 1'b0; bus.hold = 1'b0;
    clear_prog();
    do_reset();
    chk_reset_outputs("reset");
    run(4);

    // Distance-1 forward
    clear_prog(); prog[0] = 8'h16; prog[1] = 8'h29;
    do_reset(); run(3); prep();
    chk("d1_fwd_a", 8'(bus.fwd_a), 8'h00);
    chk("d1_fwd_b", 8'(bus.fwd_b), 8'h01);
    clk_adv();
    $display("dist1 forward done checks=%0d", checks);

    // Distance-2 forward
    clear_prog(); prog[0] = 8'h16; prog[1] = 8'h00; prog[2] = 8'h8D;
    do_reset(); run(4); prep();
    chk("d2_fwd_b", 8'(bus.fwd_b), 8'h02);
    clk_adv();
    $display("dist2 forward done checks=%0d", checks);

    // Load-use
    clear_prog(); prog[0] = 8'hD4; prog[1] = 8'h15;
    do_reset(); run(2); prep();
    chk("lu_pc_en", 8'(bus.pc_en), 8'h00);
    chk("lu_ifid_en", 8'(bus.ifid_en), 8'h00);
    chk("lu_bubble", 8'(bus.idex_bubble), 8'h01);
    clk_adv(); prep();
    chk("lu_after_pc_en", 8'(bus.pc_en), 8'h01);
    chk("lu_after_bubble", 8'(bus.idex_bubble), 8'h00);
    clk_adv(); prep();
    chk("lu_fwd_a", 8'(bus.fwd_a), 8'h02);
    chk("lu_fwd_b", 8'(bus.fwd_b), 8'h02);
    clk_adv();
    $display("load-use done checks=%0d", checks);

    // Branch taken while held, then released
    clear_prog(); prog[0] = 8'h90; prog[1] = 8'h16; prog[2] = 8'h29;
    do_reset(); run(2);
    br_v = 1'b1; hold_v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prep();
      chk("bh_pc_en", 8'(bus.pc_en), 8'h00);
      chk("bh_flush", 8'(bus.ifid_flush), 8'h00);
      chk("bh_bubble", 8'(bus.idex_bubble), 8'h00);
      clk_adv();
    end
    hold_v = 1'b0; tgt_v = 20; prep();
    chk("br_flush", 8'(bus.ifid_flush), 8'h01);
    chk("br_bubble", 8'(bus.idex_bubble), 8'h01);
    chk("br_pc_en", 8'(bus.pc_en), 8'h01);
    clk_adv();
    br_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prep();
      chk("br_nop_fwd_a", 8'(bus.fwd_a), 8'h00);
      chk("br_nop_fwd_b", 8'(bus.fwd_b), 8'h00);
      clk_adv();
    end
    $display("branch+hold done checks=%0d", checks);

    // LOADIMM
    clear_prog(); prog[0] = 8'hF8; prog[1] = 8'h16; prog[2] = 8'h1A;
    do_reset(); run(2); prep();
    chk("li_id_imm", 8'(bus.id_imm), 8'h01);
    chk("li_bubble", 8'(bus.idex_bubble), 8'h00);
    clk_adv(); prep();
    chk("li_imm_fwd_a", 8'(bus.fwd_a), 8'h00);
    chk("li_imm_fwd_b", 8'(bus.fwd_b), 8'h00);
    clk_adv(); prep();
    chk("li_fwd_a", 8'(bus.fwd_a), 8'h01);
    chk("li_fwd_b", 8'(bus.fwd_b), 8'h01);
    clk_adv();
    $display("loadimm done checks=%0d", checks);

    // Asynchronous reset in the middle of a stall, then in the middle of a held branch
    clear_prog(); prog[0] = 8'hD4; prog[1] = 8'h15;
    do_reset(); run(2); prep();
    chk("mid_stall_bubble", 8'(bus.idex_bubble), 8'h01);
    rst = 1'b1; #1;
    chk_reset_outputs("rst_stall");
    clear_prog(); do_reset(); run(5);
    prog[0] = 8'h90; prog[1] = 8'h16;
    do_reset(); run(3);
    br_v = 1'b1; hold_v = 1'b1; prep();
    rst = 1'b1; #1;
    chk_reset_outputs("rst_flush");
    clear_prog(); do_reset(); run(5);
    $display("mid-run reset done checks=%0d", checks);

    // Random programs with random holds and taken branches
    for (int i = 0; i < 64; i++) prog[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int n = 0; n < 600; n++) begin
      hold_v = ($urandom_range(0, 4) == 0);
      if (br_prev && hold_prev) br_v = 1'b1;
      else br_v = !m_ex.imm && (m_ex.b[7:4] inside {4'd9, 4'd10, 4'd11, 4'd12}) &&
                  ($urandom_range(0, 1) == 1);
      tgt_v = int'($urandom_range(0, 63));
      prep();
      clk_adv();
    end
    $display("random run done checks=%0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
